// File: rtl/mem_arb_pkg.sv
// Shared constants for the buffer-memory port arbiter: FSM encoding, owner ids, counter width.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    localparam logic OWN_HOST = 1'b0;
    localparam logic OWN_ENG  = 1'b1;

    localparam int unsigned CNT_W = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       win,
    output logic       any
);

    // req[0] = host, req[1] = engine
    always_comb begin
        any = |req;
        win = OWN_HOST;
        if (req == 2'b11) begin
            win = ~last;
        end else if (req[1]) begin
            win = OWN_ENG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port buffer RAM between the host path and the serial engine,
// issuing one-cycle memory commands and returning read data after a fixed latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned addr_width = 4,
    parameter int unsigned data_width = 32,
    parameter int unsigned rd_latency = 1
) (
    input  logic                  pclk,
    input  logic                  preset_i,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [addr_width-1:0] h_addr,
    input  logic [data_width-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [data_width-1:0] h_rdata,
    input  logic                  e_req,
    input  logic                  e_we,
    input  logic [addr_width-1:0] e_addr,
    input  logic [data_width-1:0] e_wdata,
    output logic                  e_gnt,
    output logic                  e_rvalid,
    output logic [data_width-1:0] e_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic [data_width-1:0] mem_rdata,
    output logic                  busy,
    output logic                  owner
);

    localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(rd_latency - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic                  cmd_we_q, cmd_we_d;
    logic [addr_width-1:0] cmd_addr_q, cmd_addr_d;
    logic [data_width-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [data_width-1:0] h_rdata_q, h_rdata_d;
    logic [data_width-1:0] e_rdata_q, e_rdata_d;
    logic                  pick_win;
    logic                  pick_any;

    rr_pick2 u_pick (
        .req  ({e_req, h_req}),
        .last (last_q),
        .win  (pick_win),
        .any  (pick_any)
    );

    always_ff @(posedge pclk or posedge preset_i) begin
        if (preset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= OWN_ENG;
            owner_q     <= OWN_HOST;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            h_rdata_q   <= '0;
            e_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            h_rdata_q   <= h_rdata_d;
            e_rdata_q   <= e_rdata_d;
        end
    end

    // Command inputs are only looked at in IDLE; everything after works from the latched copy.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        h_rdata_d   = h_rdata_q;
        e_rdata_d   = e_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_win;
                    last_d  = pick_win;
                    state_d = ST_ISSUE;
                    if (pick_win == OWN_ENG) begin
                        cmd_we_d    = e_we;
                        cmd_addr_d  = e_addr;
                        cmd_wdata_d = e_wdata;
                    end else begin
                        cmd_we_d    = h_we;
                        cmd_addr_d  = h_addr;
                        cmd_wdata_d = h_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = RD_CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_ENG) begin
                        e_rdata_d = mem_rdata;
                    end else begin
                        h_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;
    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en & cmd_we_q;
    assign mem_addr  = mem_en ? cmd_addr_q : '0;
    assign mem_wdata = mem_en ? cmd_wdata_q : '0;
    assign h_gnt     = mem_en & (owner_q == OWN_HOST);
    assign e_gnt     = mem_en & (owner_q == OWN_ENG);
    assign h_rvalid  = (state_q == ST_RESP) & (owner_q == OWN_HOST);
    assign e_rvalid  = (state_q == ST_RESP) & (owner_q == OWN_ENG);
    assign h_rdata   = h_rdata_q;
    assign e_rdata   = e_rdata_q;

endmodule
